sync_fifo_param: RTL and testbench

//  Next-generation single-clock FIFO: parametrised width/depth, registered read data with valid strobe,

---
 rtl/sync_fifo_param_pkg.sv | 31 +++
 rtl/fifo_ptr_counter.sv | 20 ++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - depth/pointer-width helpers and threshold range check for sync_fifo_param
package sync_fifo_param_pkg;

    // Number of RAM words for a given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Minimum bits needed to hold values 0..(n-1).
    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Almost-full must lie in 1..DEPTH, almost-empty in 0..DEPTH-1.
    function automatic bit fifo_thresh_ok(input int addr_width, input int af, input int ae);
        int depth;
        depth = fifo_depth(addr_width);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// rtl/fifo_ptr_counter.sv - wrapping read/write pointer with synchronous reset and enable
module fifo_ptr_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    // Advance by one on enable; natural modulo-2**WIDTH wrap carries the wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with level count and thresholds; FIFO_ERR_FLAGS_EN adds sticky Overflow/Underflow
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enqueue,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Dequeue,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  Overflow,
    output logic                  Underflow,
`endif
    output logic [ADDR_WIDTH:0]   Count
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PTR_W = fifo_ptr_width(ADDR_WIDTH);

    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_V    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_V    = PTR_W'(AE_THRESH);

    if (!fifo_thresh_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Accepts are judged against registered flags only, so no input reaches an output combinationally.
    assign wr_acc = Enqueue & ~Full & ~Rst;
    assign rd_acc = Dequeue & ~Empty & ~Rst;

    fifo_ptr_counter #(.WIDTH(PTR_W)) u_wr_ptr (
        .clk   (Clk),
        .rst   (Rst),
        .en    (wr_acc),
        .value (wr_ptr)
    );

    fifo_ptr_counter #(.WIDTH(PTR_W)) u_rd_ptr (
        .clk   (Clk),
        .rst   (Rst),
        .en    (rd_acc),
        .value (rd_ptr)
    );

    // Flags decode from registered pointers and count; wrap bit separates full from empty.
    assign Empty        = (wr_ptr == rd_ptr);
    assign Full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign Almost_Full  = (count_q >= AF_V);
    assign Almost_Empty = (count_q <= AE_V);
    assign Count        = count_q;

    // RAM write port; contents survive reset.
    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= Data_In;
        end
    end

    // Registered read port; Data_Out holds its last word when no read is accepted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
        end else if (rd_acc) begin
            Data_Out   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            Data_Valid <= 1'b1;
        end else begin
            Data_Valid <= 1'b0;
        end
    end

    // Fill level: simultaneous accepted read and write cancel out.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= (count_q == DEPTH_V) ? count_q : count_q + PTR_W'(1);
                2'b01:   count_q <= count_q - PTR_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= Overflow  | (Enqueue & Full);
            Underflow <= Underflow | (Dequeue & Empty);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (DEPTH=8, AF=6, AE=1)
module tb_sync_fifo_param;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Enqueue;
    logic [7:0] Data_In;
    logic       Dequeue;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic       Full;
    logic       Empty;
    logic       Almost_Full;
    logic       Almost_Empty;
    logic [3:0] Count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       Overflow;
    logic       Underflow;
`endif

    int total_cnt  = 0;
    int passed_cnt = 0;

    always #5 Clk = ~Clk;

    sync_fifo_param #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Enqueue      (Enqueue),
        .Data_In      (Data_In),
        .Dequeue      (Dequeue),
        .Data_Out     (Data_Out),
        .Data_Valid   (Data_Valid),
        .Full         (Full),
        .Empty        (Empty),
        .Almost_Full  (Almost_Full),
        .Almost_Empty (Almost_Empty),
`ifdef FIFO_ERR_FLAGS_EN
        .Overflow     (Overflow),
        .Underflow    (Underflow),
`endif
        .Count        (Count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: inputs already set, sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic enq, input logic [7:0] din, input logic deq);
        Enqueue = enq;
        Data_In = din;
        Dequeue = deq;
    endtask

    initial begin
        Rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        Rst = 1'b0;
        step();

        // 1: reset then idle
        chk("rst_empty",   32'(Empty),        32'd1);
        chk("rst_ae",      32'(Almost_Empty), 32'd1);
        chk("rst_full",    32'(Full),         32'd0);
        chk("rst_af",      32'(Almost_Full),  32'd0);
        chk("rst_count",   32'(Count),        32'd0);
        chk("rst_valid",   32'(Data_Valid),   32'd0);
        chk("rst_dout",    32'(Data_Out),     32'h00);

        // 2: fill 8'h00..8'h07
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
            chk("fill_count", 32'(Count),        32'(i + 1));
            chk("fill_ae",    32'(Almost_Empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
            chk("fill_af",    32'(Almost_Full),  (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("fill_full",  32'(Full),         (i + 1 == 8) ? 32'd1 : 32'd0);
            chk("fill_empty", 32'(Empty),        32'd0);
        end
        drive(1'b1, 8'hFF, 1'b0);
        step();
        chk("ovf_count", 32'(Count), 32'd8);
        chk("ovf_full",  32'(Full),  32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag",  32'(Overflow), 32'd1);
`endif

        // 3: drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            step();
            chk("drain_valid", 32'(Data_Valid), 32'd1);
            chk("drain_data",  32'(Data_Out),   32'(i));
            chk("drain_count", 32'(Count),      32'(7 - i));
        end
        chk("drain_empty", 32'(Empty), 32'd1);
        step();
        chk("udf_valid", 32'(Data_Valid), 32'd0);
        chk("udf_dout",  32'(Data_Out),   32'h07);
        chk("udf_count", 32'(Count),      32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_flag",  32'(Underflow),  32'd1);
`endif

        // 4: Count=4 then 20 cycles of simultaneous read/write across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            step();
        end
        chk("ss_count_pre", 32'(Count), 32'd4);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 8'(8'h14 + k), 1'b1);
            step();
            chk("ss_valid", 32'(Data_Valid), 32'd1);
            chk("ss_data",  32'(Data_Out),   32'(8'h10 + k));
            chk("ss_count", 32'(Count),      32'd4);
        end

        // 5: full + both -> read only; empty + both -> write only
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0);
            step();
        end
        chk("fb_full_pre", 32'(Full), 32'd1);
        drive(1'b1, 8'hEE, 1'b1);
        step();
        chk("fb_valid", 32'(Data_Valid), 32'd1);
        chk("fb_data",  32'(Data_Out),   32'h24);
        chk("fb_count", 32'(Count),      32'd7);
        chk("fb_full",  32'(Full),       32'd0);
        begin
            logic [7:0] rest [7] = '{8'h25, 8'h26, 8'h27, 8'h30, 8'h31, 8'h32, 8'h33};
            for (int i = 0; i < 7; i++) begin
                drive(1'b0, 8'h00, 1'b1);
                step();
                chk("fb_rest", 32'(Data_Out), 32'(rest[i]));
            end
        end
        chk("eb_empty_pre", 32'(Empty), 32'd1);
        drive(1'b1, 8'h55, 1'b1);
        step();
        chk("eb_valid", 32'(Data_Valid), 32'd0);
        chk("eb_count", 32'(Count),      32'd1);
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("eb_rd_valid", 32'(Data_Valid), 32'd1);
        chk("eb_rd_data",  32'(Data_Out),   32'h55);
        chk("eb_rd_empty", 32'(Empty),      32'd1);

        // 6: reset mid-burst at Count=5 with requests in the reset cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0);
            step();
        end
        chk("mr_count_pre", 32'(Count), 32'd5);
        Rst = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        step();
        Rst = 1'b0;
        chk("mr_count", 32'(Count),        32'd0);
        chk("mr_empty", 32'(Empty),        32'd1);
        chk("mr_full",  32'(Full),         32'd0);
        chk("mr_ae",    32'(Almost_Empty), 32'd1);
        chk("mr_af",    32'(Almost_Full),  32'd0);
        chk("mr_valid", 32'(Data_Valid),   32'd0);
        chk("mr_dout",  32'(Data_Out),     32'h00);
`ifdef FIFO_ERR_FLAGS_EN
        chk("mr_ovf",   32'(Overflow),     32'd0);
        chk("mr_udf",   32'(Underflow),    32'd0);
`endif
        drive(1'b1, 8'hA5, 1'b0);
        step();
        chk("mr_enq_count", 32'(Count), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("mr_deq_valid", 32'(Data_Valid), 32'd1);
        chk("mr_deq_data",  32'(Data_Out),   32'hA5);
        chk("mr_deq_empty", 32'(Empty),      32'd1);
        drive(1'b0, 8'h00, 1'b0);
        step();

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
